halt_unit: RTL and testbench

HALT_UNIT -- requirements
Module: halt_unit

---
 rtl/halt_unit.sv | 98 +++++++++
 tb/tb_halt_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/halt_unit.sv
// Halt sequencing: retires instructions in RUN, drains outstanding stores after a
// halt retires, then holds the core in HALTED with the captured return value and PC.
module halt_unit #(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic             wb_halt,
  input  logic [15:0]      wb_pc,
  input  logic [15:0]      rf_ret,
  input  logic             store_pending,
  output logic             stall,
  output logic             isHalt,
  output logic [15:0]      ret_val,
  output logic [15:0]      halt_pc,
  output logic             timed_out,
  output logic [CNT_W-1:0] retired_count
);

  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_r;
  logic [DW-1:0]    drain_cnt_r;
  logic [15:0]      ret_val_r;
  logic [15:0]      halt_pc_r;
  logic             timed_out_r;
  logic [CNT_W-1:0] retired_count_r;

  // Saturating increment: an all-ones counter stays put instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Halt FSM with drain counter and captured halt context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= RUN;
      drain_cnt_r     <= '0;
      ret_val_r       <= 16'h0000;
      halt_pc_r       <= 16'h0000;
      timed_out_r     <= 1'b0;
      retired_count_r <= '0;
    end else begin
      case (state_r)
        RUN: begin
          if (wb_valid) begin
            retired_count_r <= sat_inc(retired_count_r);
            if (wb_halt) begin
              ret_val_r   <= rf_ret;
              halt_pc_r   <= wb_pc;
              drain_cnt_r <= '0;
              state_r     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // A completed drain wins over a timeout reached in the same cycle.
          if (!store_pending) begin
            timed_out_r <= 1'b0;
            state_r     <= HALTED;
          end else if (drain_cnt_r == DRAIN_LAST) begin
            timed_out_r <= 1'b1;
            state_r     <= HALTED;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign stall         = (state_r == DRAIN) || (state_r == HALTED);
  assign isHalt        = (state_r == HALTED);
  assign ret_val       = ret_val_r;
  assign halt_pc       = halt_pc_r;
  assign timed_out     = timed_out_r;
  assign retired_count = retired_count_r;

endmodule

// File: tb/tb_halt_unit.sv
// Directed bench for halt_unit: normal halt, delayed drain, timeout, reset
// recovery and counter saturation (second instance with a 4-bit counter).
module tb_halt_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_halt, store_pending;
  logic [15:0] wb_pc, rf_ret;
  logic        stall, isHalt, timed_out;
  logic [15:0] ret_val, halt_pc;
  logic [31:0] retired_count;

  logic        wb_valid2;
  logic        wb_halt2;
  logic        stall2, isHalt2, timed_out2;
  logic [15:0] ret_val2, halt_pc2;
  logic [3:0]  retired_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  halt_unit #(.DRAIN_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_halt(wb_halt),
    .wb_pc(wb_pc), .rf_ret(rf_ret), .store_pending(store_pending),
    .stall(stall), .isHalt(isHalt), .ret_val(ret_val), .halt_pc(halt_pc),
    .timed_out(timed_out), .retired_count(retired_count)
  );

  halt_unit #(.DRAIN_TIMEOUT(64), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .wb_valid(wb_valid2), .wb_halt(wb_halt2),
    .wb_pc(16'h0000), .rf_ret(16'h0000), .store_pending(1'b0),
    .stall(stall2), .isHalt(isHalt2), .ret_val(ret_val2), .halt_pc(halt_pc2),
    .timed_out(timed_out2), .retired_count(retired_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".isHalt"}, {31'd0, isHalt}, 32'd0);
    chk({tag, ".ret_val"}, {16'd0, ret_val}, 32'd0);
    chk({tag, ".halt_pc"}, {16'd0, halt_pc}, 32'd0);
    chk({tag, ".timed_out"}, {31'd0, timed_out}, 32'd0);
    chk({tag, ".count"}, retired_count, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wb_valid = 1'b0; wb_halt = 1'b0; store_pending = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_halt = 1'b0; store_pending = 1'b0;
    wb_pc = 16'h0000; rf_ret = 16'h0000; wb_valid2 = 1'b0; wb_halt2 = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_zero("reset");
    chk("reset.sat_count", {28'd0, retired_count2}, 32'd0);

    // Five plain retirements, then an unqualified halt flag that must be ignored.
    wb_valid = 1'b1;
    tick(5);
    chk("run5.count", retired_count, 32'd5);
    wb_valid = 1'b0; wb_halt = 1'b1;
    tick(1);
    chk("nohalt.stall", {31'd0, stall}, 32'd0);
    chk("nohalt.count", retired_count, 32'd5);

    // Halt with nothing to drain: isHalt two edges after presentation.
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h0040; rf_ret = 16'h0041;
    tick(1);
    wb_valid = 1'b0; wb_halt = 1'b0;
    chk("halt.stall", {31'd0, stall}, 32'd1);
    chk("halt.isHalt_early", {31'd0, isHalt}, 32'd0);
    chk("halt.count", retired_count, 32'd6);
    tick(1);
    chk("halt.isHalt", {31'd0, isHalt}, 32'd1);
    chk("halt.ret_val", {16'd0, ret_val}, 32'h0041);
    chk("halt.halt_pc", {16'd0, halt_pc}, 32'h0040);
    chk("halt.timed_out", {31'd0, timed_out}, 32'd0);

    // Retirements while HALTED are ignored.
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h5555; rf_ret = 16'h1234;
    tick(3);
    chk("frozen.count", retired_count, 32'd6);
    chk("frozen.ret_val", {16'd0, ret_val}, 32'h0041);
    chk("frozen.halt_pc", {16'd0, halt_pc}, 32'h0040);
    chk("frozen.isHalt", {31'd0, isHalt}, 32'd1);

    // Reset out of HALTED.
    do_reset();
    chk_zero("rst_halted");

    // Stores outstanding for 10 DRAIN cycles; inputs wiggle meanwhile.
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h0100; rf_ret = 16'hBEEF; store_pending = 1'b1;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      rf_ret = 16'h1000 + 16'(i);
      wb_pc  = 16'h2000 + 16'(i);
      if (i == 9) store_pending = 1'b0;
      chk("drain.stall", {31'd0, stall}, 32'd1);
      chk("drain.isHalt", {31'd0, isHalt}, 32'd0);
      tick(1);
    end
    chk("drain.done_isHalt", {31'd0, isHalt}, 32'd1);
    chk("drain.timed_out", {31'd0, timed_out}, 32'd0);
    chk("drain.count", retired_count, 32'd1);
    chk("drain.ret_val", {16'd0, ret_val}, 32'hBEEF);
    chk("drain.halt_pc", {16'd0, halt_pc}, 32'h0100);

    // Reset in the middle of DRAIN, then a clean halt.
    do_reset();
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h0180; rf_ret = 16'h0099; store_pending = 1'b1;
    tick(1);
    wb_valid = 1'b0; wb_halt = 1'b0;
    tick(3);
    chk("predrain.stall", {31'd0, stall}, 32'd1);
    do_reset();
    chk_zero("rst_drain");
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h0200; rf_ret = 16'h0007;
    tick(1);
    wb_valid = 1'b0; wb_halt = 1'b0;
    tick(1);
    chk("rehalt.isHalt", {31'd0, isHalt}, 32'd1);
    chk("rehalt.count", retired_count, 32'd1);
    chk("rehalt.ret_val", {16'd0, ret_val}, 32'h0007);
    chk("rehalt.halt_pc", {16'd0, halt_pc}, 32'h0200);

    // Store stuck high: forced halt after exactly 64 DRAIN cycles.
    do_reset();
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h0300; rf_ret = 16'h00AA; store_pending = 1'b1;
    tick(1);
    wb_valid = 1'b0; wb_halt = 1'b0;
    tick(63);
    chk("tmo.isHalt_63", {31'd0, isHalt}, 32'd0);
    chk("tmo.stall_63", {31'd0, stall}, 32'd1);
    tick(1);
    chk("tmo.isHalt_64", {31'd0, isHalt}, 32'd1);
    chk("tmo.timed_out", {31'd0, timed_out}, 32'd1);
    chk("tmo.ret_val", {16'd0, ret_val}, 32'h00AA);
    tick(2);
    chk("tmo.hold", {31'd0, timed_out}, 32'd1);

    // Drain completes in the very cycle the timeout is reached: not a timeout.
    do_reset();
    chk("tmo.cleared", {31'd0, timed_out}, 32'd0);
    wb_valid = 1'b1; wb_halt = 1'b1; wb_pc = 16'h0400; rf_ret = 16'h00BB; store_pending = 1'b1;
    tick(1);
    wb_valid = 1'b0; wb_halt = 1'b0;
    tick(63);
    store_pending = 1'b0;
    tick(1);
    chk("race.isHalt", {31'd0, isHalt}, 32'd1);
    chk("race.timed_out", {31'd0, timed_out}, 32'd0);

    // Saturation on the 4-bit instance.
    do_reset();
    wb_valid2 = 1'b1;
    tick(15);
    chk("sat.count15", {28'd0, retired_count2}, 32'd15);
    tick(5);
    chk("sat.count20", {28'd0, retired_count2}, 32'd15);
    chk("sat.stall", {31'd0, stall2}, 32'd0);
    wb_valid2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
